service_counter_bank: RTL and testbench

- Bank of CNTER service counters directly downstream of the dispatcher.
- Each counter accepts one customer on its ld strobe, latches the customer number and service time, and counts the service time down in prescaled time units.
- It then raises a completion report that a downstream consumer (display/logger) acknowledges with a valid/ready handshake.
- It drives the busy vector the dispatcher uses to pick a free counter.

---
 rtl/service_counter_bank_if.sv | 30 +++
 rtl/service_counter_bank.sv | 130 +++++++++++++
 tb/tb_service_counter_bank.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/service_counter_bank_if.sv
// Dispatcher/consumer-facing bundle of the service counter bank: load strobes,
// per-counter status and the completion report handshake.
interface service_counter_bank_if #(
  parameter int DT_SZ = 4,
  parameter int CNTER = 3,
  parameter int SC_W  = 8
);
  logic [CNTER-1:0]       ld;
  logic [DT_SZ-1:0]       dn;
  logic [DT_SZ-1:0]       dt;
  logic [CNTER-1:0]       busy;
  logic [CNTER*DT_SZ-1:0] cur_n;
  logic [CNTER*DT_SZ-1:0] rem_t;
  logic                   done_v;
  logic                   done_rdy;
  logic [1:0]             done_id;
  logic [DT_SZ-1:0]       done_n;
  logic [SC_W-1:0]        served;
  logic                   ld_err;

  modport master (
    output ld, dn, dt, done_rdy,
    input  busy, cur_n, rem_t, done_v, done_id, done_n, served, ld_err
  );

  modport slave (
    input  ld, dn, dt, done_rdy,
    output busy, cur_n, rem_t, done_v, done_id, done_n, served, ld_err
  );
endinterface

// File: rtl/service_counter_bank.sv
// Bank of service counters: each loads a customer, counts its service time down
// in prescaled units, then holds a completion report until it is accepted.
module service_counter_bank #(
  parameter int DT_SZ    = 4,
  parameter int CNTER    = 3,
  parameter int TICK_DIV = 4,
  parameter int SC_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  service_counter_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, REPORT = 2'd2} state_e;

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_e           st_q  [CNTER];
  state_e           st_d  [CNTER];
  logic [DT_SZ-1:0] cur_q [CNTER];
  logic [DT_SZ-1:0] cur_d [CNTER];
  logic [DT_SZ-1:0] rem_q [CNTER];
  logic [DT_SZ-1:0] rem_d [CNTER];
  logic [PW-1:0]    presc_q, presc_d;
  logic [SC_W-1:0]  served_q, served_d;
  logic             err_q, err_d;

  logic             tick;
  logic             accept;
  logic             dv;
  logic [1:0]       did;
  logic [DT_SZ-1:0] dnum;
  logic [CNTER-1:0] in_use;
  logic [CNTER-1:0] ld_sel;
  logic             ld_multi;

  always_comb begin
    tick    = (presc_q == PMAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Fixed-priority report selection: the lowest index in REPORT wins.
  always_comb begin
    dv   = 1'b0;
    did  = '0;
    dnum = '0;
    for (int i = CNTER - 1; i >= 0; i--) begin
      if (st_q[i] == REPORT) begin
        dv   = 1'b1;
        did  = 2'(i);
        dnum = cur_q[i];
      end
    end
    accept = dv & bus.done_rdy;
  end

  always_comb begin
    for (int i = 0; i < CNTER; i++) in_use[i] = (st_q[i] != IDLE);
    ld_sel   = bus.ld & (~bus.ld + CNTER'(1));
    ld_multi = |(bus.ld & (bus.ld - CNTER'(1)));
    err_d    = err_q | ld_multi | (|(bus.ld & in_use));
    served_d = accept ? served_q + SC_W'(1) : served_q;
  end

  always_comb begin
    for (int i = 0; i < CNTER; i++) begin
      st_d[i]  = st_q[i];
      cur_d[i] = cur_q[i];
      rem_d[i] = rem_q[i];
      case (st_q[i])
        IDLE: begin
          if (ld_sel[i]) begin
            st_d[i]  = SERVE;
            cur_d[i] = bus.dn;
            rem_d[i] = (bus.dt == '0) ? DT_SZ'(1) : bus.dt;
          end
        end
        SERVE: begin
          if (tick) begin
            if (rem_q[i] == DT_SZ'(1)) begin
              rem_d[i] = '0;
              st_d[i]  = REPORT;
            end else begin
              rem_d[i] = rem_q[i] - DT_SZ'(1);
            end
          end
        end
        REPORT: begin
          if (accept && did == 2'(i)) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      served_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < CNTER; i++) begin
        st_q[i]  <= IDLE;
        cur_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      served_q <= served_d;
      err_q    <= err_d;
      for (int i = 0; i < CNTER; i++) begin
        st_q[i]  <= st_d[i];
        cur_q[i] <= cur_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  // The ld term blocks a second load to a counter at the edge its first is sampled.
  assign bus.busy    = in_use | bus.ld;
  assign bus.done_v  = dv;
  assign bus.done_id = did;
  assign bus.done_n  = dnum;
  assign bus.served  = served_q;
  assign bus.ld_err  = err_q;

  for (genvar g = 0; g < CNTER; g++) begin : g_out
    assign bus.cur_n[g*DT_SZ +: DT_SZ] = cur_q[g];
    assign bus.rem_t[g*DT_SZ +: DT_SZ] = rem_q[g];
  end
endmodule

// File: tb/tb_service_counter_bank.sv
// Bench for service_counter_bank: a directed table, corner-case sequences and
// random traffic, all checked against a customer-level reference model.
module tb_service_counter_bank;
  localparam int DT_SZ = 4;
  localparam int CNTER = 3;
  localparam int TD    = 4;
  localparam int SC_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  service_counter_bank_if #(.DT_SZ(DT_SZ), .CNTER(CNTER), .SC_W(SC_W)) bus ();

  service_counter_bank #(.DT_SZ(DT_SZ), .CNTER(CNTER), .TICK_DIV(TD), .SC_W(SC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: a counter is occupied by a customer who needs 'units' ticks and has had 'tks'.
  int occ   [CNTER];
  int num   [CNTER];
  int units [CNTER];
  int tks   [CNTER];
  int served_m, err_m, e_m;

  typedef struct {
    logic [2:0] ld;
    logic [3:0] dn;
    logic [3:0] dt;
    logic       rdy;
    logic [2:0] busy;
    logic       dv;
    logic [1:0] did;
    logic [3:0] dnm;
    logic [3:0] cur0;
    logic [3:0] rem0;
    logic [7:0] srv;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CNTER; i++) begin
      occ[i] = 0; num[i] = 0; units[i] = 0; tks[i] = 0;
    end
    served_m = 0; err_m = 0; e_m = 0;
  endtask

  function automatic int rem_of(input int i);
    return occ[i] ? units[i] - tks[i] : 0;
  endfunction

  task automatic model_check();
    logic [2:0]  eb;
    logic [11:0] ec, er;
    int dv, did;
    dv = 0; did = 0;
    for (int i = CNTER - 1; i >= 0; i--)
      if (occ[i] && rem_of(i) == 0) begin dv = 1; did = i; end
    for (int i = 0; i < CNTER; i++) begin
      eb[i]         = (occ[i] != 0) | bus.ld[i];
      ec[i*4 +: 4]  = 4'(num[i]);
      er[i*4 +: 4]  = 4'(rem_of(i));
    end
    chk("busy", bus.busy, eb);
    chk("cur_n", bus.cur_n, ec);
    chk("rem_t", bus.rem_t, er);
    chk("done_v", bus.done_v, dv);
    if (dv) begin
      chk("done_id", bus.done_id, did);
      chk("done_n", bus.done_n, num[did] % 16);
    end
    chk("served", bus.served, served_m);
    chk("ld_err", bus.ld_err, err_m);
  endtask

  task automatic model_step();
    int occ_pre [CNTER];
    int dv, did, tick, j;
    if (rst) begin
      model_reset();
      return;
    end
    dv = 0; did = 0;
    for (int i = CNTER - 1; i >= 0; i--)
      if (occ[i] && rem_of(i) == 0) begin dv = 1; did = i; end
    tick = ((e_m % TD) == TD - 1);
    for (int i = 0; i < CNTER; i++) occ_pre[i] = occ[i];
    for (int i = 0; i < CNTER; i++)
      if (occ[i] && rem_of(i) > 0 && tick) tks[i]++;
    if (dv && bus.done_rdy) begin
      occ[did] = 0;
      served_m = (served_m + 1) % (1 << SC_W);
    end
    j = -1;
    for (int i = CNTER - 1; i >= 0; i--) if (bus.ld[i]) j = i;
    if (j >= 0 && !occ_pre[j]) begin
      occ[j] = 1; num[j] = bus.dn; units[j] = (bus.dt == 0) ? 1 : bus.dt; tks[j] = 0;
    end
    if ($countones(bus.ld) > 1) err_m = 1;
    for (int i = 0; i < CNTER; i++) if (bus.ld[i] && occ_pre[i]) err_m = 1;
    e_m++;
  endtask

  task automatic apply(input logic [2:0] l, input logic [3:0] n, input logic [3:0] t, input logic r);
    bus.ld = l; bus.dn = n; bus.dt = t; bus.done_rdy = r;
    #4;
    model_check();
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    adv();
    rst = 1'b0;
  endtask

  task automatic align();
    for (int k = 0; k < TD && (e_m % TD) != 0; k++) begin
      apply(3'b000, 4'd0, 4'd0, 1'b0);
      adv();
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((bus.busy != 3'b000 || bus.done_v) && k < budget) begin
      apply(3'b000, 4'd0, 4'd0, 1'b1);
      adv();
      k++;
    end
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    chk("drain_timeout", bus.busy, 3'b000);
  endtask

  initial begin
    int s0, k;
    logic [2:0] l;
    bus.ld = '0; bus.dn = '0; bus.dt = '0; bus.done_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      apply(3'b000, 4'd0, 4'd0, 1'b0);
      adv();
    end
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    chk("idle_busy", bus.busy, 3'b000);
    chk("idle_done_v", bus.done_v, 0);
    chk("idle_served", bus.served, 0);
    chk("idle_ld_err", bus.ld_err, 0);
    chk("idle_rem_t", bus.rem_t, 0);

    tbl[0] = '{3'b001, 4'd5, 4'd3, 1'b1, 3'b001, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 8'd0};
    for (int v = 1; v <= 11; v++)
      tbl[v] = '{3'b000, 4'd0, 4'd0, 1'b1, 3'b001, 1'b0, 2'd0, 4'd0, 4'd5,
                 (v <= 3) ? 4'd3 : (v <= 7) ? 4'd2 : 4'd1, 8'd0};
    tbl[12] = '{3'b000, 4'd0, 4'd0, 1'b1, 3'b001, 1'b1, 2'd0, 4'd5, 4'd5, 4'd0, 8'd0};
    tbl[13] = '{3'b000, 4'd0, 4'd0, 1'b1, 3'b000, 1'b0, 2'd0, 4'd0, 4'd5, 4'd0, 8'd1};

    do_reset();
    for (int v = 0; v < 14; v++) begin
      apply(tbl[v].ld, tbl[v].dn, tbl[v].dt, tbl[v].rdy);
      chk("tbl_busy", bus.busy, tbl[v].busy);
      chk("tbl_done_v", bus.done_v, tbl[v].dv);
      if (tbl[v].dv) begin
        chk("tbl_done_id", bus.done_id, tbl[v].did);
        chk("tbl_done_n", bus.done_n, tbl[v].dnm);
      end
      chk("tbl_cur0", bus.cur_n[3:0], tbl[v].cur0);
      chk("tbl_rem0", bus.rem_t[3:0], tbl[v].rem0);
      chk("tbl_served", bus.served, tbl[v].srv);
      adv();
    end

    // Two counters finishing on the same tick, report held while not ready.
    align();
    s0 = served_m;
    apply(3'b001, 4'd7, 4'd2, 1'b0); adv();
    apply(3'b100, 4'd9, 4'd2, 1'b0); adv();
    k = 0;
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    while (!bus.done_v && k < 16) begin adv(); apply(3'b000, 4'd0, 4'd0, 1'b0); k++; end
    chk("pair_report_timeout", bus.done_v, 1);
    chk("pair_rem_both0", {bus.rem_t[11:8], bus.rem_t[3:0]}, 0);
    for (int c = 0; c < 5; c++) begin
      apply(3'b000, 4'd0, 4'd0, 1'b0);
      chk("hold_id", bus.done_id, 0);
      chk("hold_busy", bus.busy, 3'b101);
      adv();
    end
    apply(3'b000, 4'd0, 4'd0, 1'b1);
    chk("acc_first_id", bus.done_id, 0);
    chk("acc_first_n", bus.done_n, 7);
    adv();
    apply(3'b000, 4'd0, 4'd0, 1'b1);
    chk("acc_second_id", bus.done_id, 2);
    chk("acc_second_n", bus.done_n, 9);
    adv();
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    chk("pair_done_v", bus.done_v, 0);
    chk("pair_served", bus.served, (s0 + 2) % 256);

    // Zero service time counts as one unit.
    apply(3'b010, 4'd11, 4'd0, 1'b1); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b1);
    chk("dt0_rem", bus.rem_t[7:4], 1);
    drain(20);

    // Illegal loads: to a serving counter and with several strobes.
    do_reset();
    apply(3'b010, 4'd3, 4'd5, 1'b1); adv();
    apply(3'b010, 4'd8, 4'd2, 1'b1); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b1);
    chk("err_set", bus.ld_err, 1);
    chk("err_cur1", bus.cur_n[7:4], 3);
    drain(40);
    chk("err_sticky", bus.ld_err, 1);
    apply(3'b011, 4'd6, 4'd1, 1'b0); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    chk("multi_busy", bus.busy, 3'b001);
    chk("multi_cur0", bus.cur_n[3:0], 6);

    // Reset while one counter reports and another is mid-service.
    drain(20);
    align();
    apply(3'b001, 4'd2, 4'd1, 1'b0); adv();
    apply(3'b010, 4'd4, 4'd3, 1'b0); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b0); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b0); adv();
    apply(3'b000, 4'd0, 4'd0, 1'b0);
    chk("pre_rst_report", bus.done_v, 1);
    chk("pre_rst_rem1", bus.rem_t[7:4], 2);
    do_reset();
    apply(3'b000, 4'd0, 4'd0, 1'b1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done_v", bus.done_v, 0);
    chk("rst_served", bus.served, 0);
    chk("rst_cur", bus.cur_n, 0);
    chk("rst_rem", bus.rem_t, 0);
    chk("rst_err", bus.ld_err, 0);
    adv();

    for (int c = 0; c < 3000; c++) begin
      k = $urandom_range(0, 99);
      if (k < 55) l = 3'b000;
      else if (k < 92) l = 3'(1 << $urandom_range(0, 2));
      else l = 3'($urandom_range(0, 7));
      if (c % 700 == 699) begin
        rst = 1'b1;
        apply(l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        adv();
        rst = 1'b0;
      end else begin
        apply(l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        adv();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
